// File: rtl/spi_mem_pkg.sv
// Shared opcodes, FSM states and lane helpers for the SPI SRAM bridge.
// Fast-read build option: SPI_FAST_READ_EN.
package spi_mem_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam int         DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE,
        S_GAP
    } state_t;

    function automatic logic [1:0] sel_lo(input logic [3:0] sel);
        if (sel[0])      return 2'd0;
        else if (sel[1]) return 2'd1;
        else if (sel[2]) return 2'd2;
        else             return 2'd3;
    endfunction

    function automatic logic [1:0] sel_hi(input logic [3:0] sel);
        if (sel[3])      return 2'd3;
        else if (sel[2]) return 2'd2;
        else if (sel[1]) return 2'd1;
        else             return 2'd0;
    endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// SPI mode-0 byte engine: SCK divider, MSB-first shift out/in, byte strobe.
// Fast-read build option: SPI_FAST_READ_EN (no effect here).
module spi_mem_shifter
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_tx,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_byte_done,
    output logic [7:0] o_rx
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_sck;
    logic          r_busy;
    logic          w_phase_end;

    assign w_phase_end = r_busy && (r_div == DIV_LAST);
    assign o_byte_done = w_phase_end && r_sck && (r_bit == 3'd7);
    assign o_rx        = {r_rx[6:0], i_miso};
    assign o_sck       = r_sck;
    assign o_mosi      = r_tx[7];

    // A load on the byte-end edge chains bytes with no idle SCK period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_sck  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_busy <= 1'b1;
            r_tx   <= i_tx;
            r_bit  <= '0;
            r_div  <= '0;
            r_sck  <= 1'b0;
        end else if (w_phase_end) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (r_sck) begin
                r_rx  <= o_rx;
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
                if (r_bit == 3'd7) r_busy <= 1'b0;
            end
        end else if (r_busy) begin
            r_div <= r_div + DW'(1);
        end
    end

endmodule

// File: rtl/spi_mem_wb_bridge.sv
// Wishbone-classic slave mapping 32-bit loads/stores onto a 23LC-style SPI SRAM.
// Build option SPI_FAST_READ_EN: reads use 0x0B plus one dummy byte.
module spi_mem_wb_bridge
    import spi_mem_pkg::*;
#(
    parameter int AW         = 15,
    parameter int ADDR_BYTES = 2,
    parameter int CLK_DIV    = 1,
    parameter int CS_IDLE    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    input  logic          i_wb_we,
    input  logic          i_wb_cyc,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          spi_sck,
    output logic          spi_ss,
    output logic          spi_mosi,
    input  logic          spi_miso
);

    localparam int AFW         = ADDR_BYTES * 8;
    localparam int DUMMY_BYTES = DUMMY_BITS / 8;
    localparam int CNT_MAX     = (ADDR_BYTES > DUMMY_BYTES) ? ADDR_BYTES : DUMMY_BYTES;
    localparam int CW          = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GW          = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] RD_OP = OP_FREAD;
`else
    localparam logic [7:0] RD_OP = OP_READ;
`endif

    state_t          r_state;
    state_t          w_nxt;
    logic [AFW-1:0]  r_addr;
    logic [31:0]     r_wdat;
    logic [31:0]     r_rdt;
    logic [23:0]     r_rbuf;
    logic [1:0]      r_lane;
    logic [1:0]      r_hi;
    logic            r_we;
    logic            r_ack;
    logic            r_ss;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;

    logic            w_load;
    logic [7:0]      w_tx;
    logic            w_byte_done;
    logic [7:0]      w_rx;
    logic [1:0]      w_lo;
    logic [1:0]      w_hi;
    logic [1:0]      w_lane_n;
    logic [AW-1:0]   w_start;
    logic            w_wr_nop;
    logic            w_last_lane;
    logic            w_unused;

    assign w_lo        = sel_lo(i_wb_sel);
    assign w_hi        = sel_hi(i_wb_sel);
    assign w_start     = {i_wb_adr[AW-1:2], (i_wb_we ? w_lo : 2'b00)};
    assign w_wr_nop    = i_wb_we && (i_wb_sel == 4'b0000);
    assign w_lane_n    = r_lane + 2'd1;
    assign w_last_lane = (r_lane == r_hi);
    assign w_unused    = &{1'b0, i_wb_adr[1:0]};

    assign o_wb_rdt = r_rdt;
    assign o_wb_ack = r_ack;
    assign spi_ss   = r_ss;

    spi_mem_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_tx        (w_tx),
        .i_miso      (spi_miso),
        .o_sck       (spi_sck),
        .o_mosi      (spi_mosi),
        .o_byte_done (w_byte_done),
        .o_rx        (w_rx)
    );

    always_comb begin
        w_nxt  = r_state;
        w_load = 1'b0;
        w_tx   = 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    if (w_wr_nop) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_nxt  = S_CMD;
                        w_load = 1'b1;
                        w_tx   = i_wb_we ? OP_WRITE : RD_OP;
                    end
                end
            end
            S_CMD: begin
                if (w_byte_done) begin
                    w_nxt  = S_ADDR;
                    w_load = 1'b1;
                    w_tx   = r_addr[AFW-1 -: 8];
                end
            end
            S_ADDR: begin
                if (w_byte_done) begin
                    w_load = 1'b1;
                    if (r_cnt != '0) begin
                        w_tx = r_addr[AFW-1 -: 8];
                    end else if (r_we) begin
                        w_nxt = S_DATA;
                        w_tx  = r_wdat[{r_lane, 3'b000} +: 8];
                    end else begin
`ifdef SPI_FAST_READ_EN
                        w_nxt = S_DUMMY;
`else
                        w_nxt = S_DATA;
`endif
                    end
                end
            end
            S_DUMMY: begin
                if (w_byte_done) begin
                    w_load = 1'b1;
                    if (r_cnt == '0) w_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_byte_done) begin
                    if (w_last_lane) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_tx   = r_we ? r_wdat[{w_lane_n, 3'b000} +: 8] : 8'h00;
                    end
                end
            end
            S_DONE: w_nxt = S_GAP;
            S_GAP:  if (r_gap == '0) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdat  <= '0;
            r_rdt   <= '0;
            r_rbuf  <= '0;
            r_lane  <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_ss    <= 1'b1;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nxt;
            r_ack   <= (w_nxt == S_DONE);
            r_ss    <= !(w_nxt inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
            unique case (r_state)
                S_IDLE: begin
                    if (i_wb_cyc) begin
                        r_we   <= i_wb_we;
                        r_wdat <= i_wb_dat;
                        r_addr <= AFW'(w_start);
                        r_lane <= i_wb_we ? w_lo : 2'd0;
                        r_hi   <= i_wb_we ? w_hi : 2'd3;
                    end
                end
                S_CMD: begin
                    if (w_byte_done) begin
                        r_addr <= r_addr << 8;
                        r_cnt  <= CW'(ADDR_BYTES - 1);
                    end
                end
                S_ADDR: begin
                    if (w_byte_done) begin
                        if (r_cnt != '0) begin
                            r_addr <= r_addr << 8;
                            r_cnt  <= r_cnt - CW'(1);
                        end else begin
                            r_cnt <= CW'(DUMMY_BYTES - 1);
                        end
                    end
                end
                S_DUMMY: if (w_byte_done) r_cnt <= r_cnt - CW'(1);
                S_DATA: begin
                    // Read bytes arrive lane 0 first; shift them down from the top.
                    if (w_byte_done) begin
                        r_rbuf <= {w_rx, r_rbuf[23:8]};
                        if (w_last_lane) begin
                            if (!r_we) r_rdt <= {w_rx, r_rbuf};
                        end else begin
                            r_lane <= w_lane_n;
                        end
                    end
                end
                S_DONE: r_gap <= GW'(CS_IDLE - 1);
                S_GAP:  r_gap <= r_gap - GW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_wb_bridge.sv
// Randomized bench for spi_mem_wb_bridge with a behavioural SPI SRAM model.
// Build option SPI_FAST_READ_EN switches the expected read framing.
module tb_spi_mem_wb_bridge;

`ifdef SPI_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [7:0] RD_OP = FAST ? 8'h0B : 8'h03;
    localparam int LIMIT = 3000;
    localparam int GAP   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic [1:0]  we  = '0;
    logic [1:0]  cyc = '0;
    logic [63:0] rdt;
    logic [1:0]  ack;
    logic [1:0]  sck;
    logic [1:0]  ss;
    logic [1:0]  mosi;
    logic [1:0]  miso;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_mem_wb_bridge #(
        .AW(15), .ADDR_BYTES(2), .CLK_DIV(1), .CS_IDLE(GAP)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
        .i_wb_we(we[0]), .i_wb_cyc(cyc[0]),
        .o_wb_rdt(rdt[31:0]), .o_wb_ack(ack[0]),
        .spi_sck(sck[0]), .spi_ss(ss[0]),
        .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_mem_wb_bridge #(
        .AW(15), .ADDR_BYTES(3), .CLK_DIV(3), .CS_IDLE(GAP)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
        .i_wb_we(we[1]), .i_wb_cyc(cyc[1]),
        .o_wb_rdt(rdt[63:32]), .o_wb_ack(ack[1]),
        .spi_sck(sck[1]), .spi_ss(ss[1]),
        .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    // SPI SRAM model: frame decoded bit by bit, memory as a byte array.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        localparam int AB = (g == 0) ? 2 : 3;
        logic [7:0]  mem [65536];
        logic [7:0]  fb  [16];
        logic [7:0]  cur;
        logic [7:0]  op;
        logic [23:0] a;
        logic        so;
        int          nb;
        int          hi;
        int          lo;

        assign miso[g] = so;

        initial begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
            mem[16'h0104] = 8'h11;
            mem[16'h0105] = 8'h22;
            mem[16'h0106] = 8'h33;
            mem[16'h0107] = 8'h44;
            so = 1'b0; nb = 0; cur = '0; op = '0; a = '0;
        end

        always @(posedge sck[g] or negedge ss[g]) begin
            if (!sck[g]) begin
                nb = 0;
            end else if (!ss[g]) begin
                int n, k, hdr;
                cur = {cur[6:0], mosi[g]};
                n = nb;
                nb++;
                if (nb % 8 == 0 && nb / 8 <= 16) fb[nb/8-1] = cur;
                if (nb == 8) begin
                    op = cur;
                    a  = '0;
                end else if (nb % 8 == 0 && nb <= 8 + 8*AB) begin
                    a = {a[15:0], cur};
                end
                hdr = 8 + 8*AB + ((op == 8'h0B) ? 8 : 0);
                if (op == 8'h02 && nb > 8 + 8*AB && nb % 8 == 0)
                    mem[16'(a + 24'((nb - 8 - 8*AB) / 8 - 1))] = cur;
                if ((op == 8'h03 || op == 8'h0B) && n >= hdr) begin
                    k  = n - hdr;
                    so = mem[16'(a + 24'(k / 8))][7 - k % 8];
                end
            end
        end

        always @(posedge clk) begin
            if (ss[g]) begin
                hi = 0;
                lo = 0;
            end else if (sck[g]) hi++;
            else lo++;
        end
    end

    function automatic logic [7:0] mem_rd(input int d, input int ad);
        if (d == 0) return g_sram[0].mem[ad[15:0]];
        return g_sram[1].mem[ad[15:0]];
    endfunction

    function automatic logic [7:0] fb_rd(input int d, input int i);
        if (d == 0) return g_sram[0].fb[i];
        return g_sram[1].fb[i];
    endfunction

    function automatic int cnt_rd(input int d, input int which);
        if (d == 0) return which == 0 ? g_sram[0].nb : which == 1 ? g_sram[0].hi : g_sram[0].lo;
        return which == 0 ? g_sram[1].nb : which == 1 ? g_sram[1].hi : g_sram[1].lo;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input int d, input bit w, input logic [14:0] a,
                       input logic [31:0] wd, input logic [3:0] s, input string tag);
        int ab, cd, hdrb, nbytes, nbits, lo, hi, ackc, n, start;
        bit noop;
        logic [7:0] exp[$];
        logic [31:0] er;
        ab = (d == 0) ? 2 : 3;
        cd = (d == 0) ? 1 : 3;
        lo = 0;
        hi = 3;
        exp = {};
        if (w) begin
            for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
            for (int i = 0; i < 4; i++)  if (s[i]) hi = i;
        end
        start = (int'(a) & ~3) + (w ? lo : 0);
        exp.push_back(w ? 8'h02 : RD_OP);
        for (int i = ab - 1; i >= 0; i--) exp.push_back(8'(start >> (8*i)));
        hdrb = exp.size();
        if (w) for (int i = lo; i <= hi; i++) exp.push_back(wd[8*i +: 8]);
        nbytes = w ? exp.size() : hdrb + (FAST ? 1 : 0) + 4;
        nbits  = 8 * nbytes;
        noop   = w && (s == 4'b0000);
        ackc   = noop ? 1 : 1 + 2*cd*nbits;
        er = {mem_rd(d, start + 3), mem_rd(d, start + 2), mem_rd(d, start + 1), mem_rd(d, start)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = wd; sel[d] = s;
        @(posedge clk);
        #1;
        dat[d] = $urandom;
        adr[d] = 15'($urandom);
        n = 1;
        while (!ack[d] && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".ack_cycle"}, n, ackc);
        cyc[d] = 1'b0;
        chk({tag, ".ss_done"}, 32'(ss[d]), 1);
        if (!w) chk({tag, ".rdt"}, d ? rdt[63:32] : rdt[31:0], er);
        if (noop) begin
            chk({tag, ".ss_low_cycles"}, cnt_rd(d, 1) + cnt_rd(d, 2), 0);
        end else begin
            chk({tag, ".bits"}, cnt_rd(d, 0), nbits);
            chk({tag, ".sck_hi"}, cnt_rd(d, 1), cd*nbits);
            chk({tag, ".sck_lo"}, cnt_rd(d, 2), cd*nbits);
            for (int i = 0; i < exp.size(); i++)
                chk($sformatf("%s.mosi%0d", tag, i), fb_rd(d, i), exp[i]);
        end
        for (int i = 0; i < GAP; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s.gap_ss%0d", tag, i), 32'(ss[d]), 1);
            chk($sformatf("%s.gap_ack%0d", tag, i), 32'(ack[d]), 0);
        end
        if (w && !noop)
            for (int i = lo; i <= hi; i++)
                chk($sformatf("%s.mem%0d", tag, i), mem_rd(d, start + i - lo), wd[8*i +: 8]);
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; dat[i] = '0; sel[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d.ss", i), 32'(ss[i]), 1);
            chk($sformatf("rst%0d.sck", i), 32'(sck[i]), 0);
            chk($sformatf("rst%0d.mosi", i), 32'(mosi[i]), 0);
            chk($sformatf("rst%0d.ack", i), 32'(ack[i]), 0);
        end
        chk("rst.rdt", 32'(rdt[31:0] | rdt[63:32]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 1'b0, 15'h0106, 32'h0, 4'h0, "rd_dir");
        run(0, 1'b1, 15'h0010, 32'hAABBCCDD, 4'b1100, "wr_dir");
        run(0, 1'b1, 15'h0200, 32'h12345678, 4'b0000, "wr_nop");
        run(1, 1'b0, 15'h0106, 32'h0, 4'h0, "rd_div3");
        run(1, 1'b1, 15'h0041, 32'hCAFEF00D, 4'b0110, "wr_div3");
        run(0, 1'b1, 15'h7FFC, 32'h01020304, 4'b1001, "wr_span");
        run(0, 1'b0, 15'h7FFF, 32'h0, 4'h0, "rd_top");

        for (int t = 0; t < 20; t++) begin
            int d;
            bit w;
            d = int'($urandom_range(0, 1));
            w = 1'($urandom);
            run(d, w, 15'($urandom), $urandom, 4'($urandom), $sformatf("rnd%0d", t));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc[0] = 1'b1; we[0] = 1'b0; adr[0] = 15'h0300; sel[0] = 4'hF;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cyc[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.ss", 32'(ss[0]), 1);
        chk("midrst.sck", 32'(sck[0]), 0);
        chk("midrst.ack", 32'(ack[0]), 0);
        chk("midrst.rdt", rdt[31:0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ack[0]) acks++;
        end
        chk("midrst.no_ack", acks, 0);
        run(0, 1'b0, 15'h0105, 32'h0, 4'h0, "rd_after_rst");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
